// File: rtl/sprite_compositor.sv
// Sprite overlay stage: maps display pixels to sprite-local ROM coordinates and
// substitutes masked ROM colour for the background, gated by a visibility FSM.
module sprite_compositor #(
    parameter int SPR_W        = 16,
    parameter int SPR_H        = 16,
    parameter int SHIFT        = 0,
    parameter int BLINK_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic        de,
    input  logic        frame_start,
    input  logic [7:0]  bg_r,
    input  logic [7:0]  bg_g,
    input  logic [7:0]  bg_b,
    input  logic [10:0] pos_x,
    input  logic [10:0] pos_y,
    input  logic        show,
    input  logic        blink,
    output logic [10:0] spr_x,
    output logic [10:0] spr_y,
    input  logic [7:0]  rom_r,
    input  logic [7:0]  rom_g,
    input  logic [7:0]  rom_b,
    input  logic        rom_mask,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic        out_de
);

    localparam int STAGES = 2;
    localparam logic [11:0] BOX_W = 12'(SPR_W << SHIFT);
    localparam logic [11:0] BOX_H = 12'(SPR_H << SHIFT);
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {HIDDEN, VISIBLE, BLINK_ON, BLINK_OFF} vis_state_t;

    logic [10:0]       cur_x, cur_y;
    vis_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic              vis;
    logic [STAGES:1]   vld_pipe;
    rgb_t              bg1, out_pix;
    logic              inbox1;

    // Position only moves at frame start so a frame never tears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x <= '0;
            cur_y <= '0;
        end else if (frame_start) begin
            cur_x <= pos_x;
            cur_y <= pos_y;
        end
    end

    // 12-bit box arithmetic: a sprite near x/y=2047 clips instead of wrapping to 0.
    logic [11:0] px12, py12, cx12, cy12, dx, dy, x_end, y_end;
    logic        inbox_c;

    always_comb begin
        px12    = {1'b0, pix_x};
        py12    = {1'b0, pix_y};
        cx12    = {1'b0, cur_x};
        cy12    = {1'b0, cur_y};
        dx      = px12 - cx12;
        dy      = py12 - cy12;
        x_end   = cx12 + BOX_W;
        y_end   = cy12 + BOX_H;
        inbox_c = de && (px12 >= cx12) && (px12 < x_end)
                     && (py12 >= cy12) && (py12 < y_end);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spr_x    <= '0;
            spr_y    <= '0;
            inbox1   <= 1'b0;
            bg1      <= '0;
            out_pix  <= '0;
            vld_pipe <= '0;
        end else begin
            spr_x    <= inbox_c ? 11'(dx >> SHIFT) : '0;
            spr_y    <= inbox_c ? 11'(dy >> SHIFT) : '0;
            inbox1   <= inbox_c;
            bg1      <= '{r: bg_r, g: bg_g, b: bg_b};
            vld_pipe <= {vld_pipe[STAGES-1:1], de};
            // ROM data is only trusted inside the box; mask outside is ignored.
            if (inbox1 && vis && rom_mask)
                out_pix <= '{r: rom_r, g: rom_g, b: rom_b};
            else
                out_pix <= bg1;
        end
    end

    assign out_r  = out_pix.r;
    assign out_g  = out_pix.g;
    assign out_b  = out_pix.b;
    assign out_de = vld_pipe[STAGES];

    // Visibility FSM; show/blink are only looked at on frame_start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= HIDDEN;
            cnt   <= '0;
            vis   <= 1'b0;
        end else if (frame_start) begin
            case (state)
                HIDDEN: begin
                    cnt <= '0;
                    if (show) begin
                        state <= blink ? BLINK_ON : VISIBLE;
                        vis   <= 1'b1;
                    end
                end
                VISIBLE: begin
                    cnt <= '0;
                    if (!show) begin
                        state <= HIDDEN;
                        vis   <= 1'b0;
                    end else if (blink) begin
                        state <= BLINK_ON;
                        vis   <= 1'b1;
                    end
                end
                BLINK_ON, BLINK_OFF: begin
                    if (!show) begin
                        state <= HIDDEN;
                        vis   <= 1'b0;
                        cnt   <= '0;
                    end else if (!blink) begin
                        state <= VISIBLE;
                        vis   <= 1'b1;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= (state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                        vis   <= (state != BLINK_ON);
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= HIDDEN;
                    vis   <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: one unscaled DUT and one SHIFT=1 DUT
// share stimulus; ROM is modelled as constant colour with a driven mask.
module tb_sprite_compositor;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] pix_x, pix_y, pos_x, pos_y;
    logic        de, frame_start, show, blink;
    logic [7:0]  bg_r, bg_g, bg_b, rom_r, rom_g, rom_b;
    logic        rom_mask;

    logic [10:0] spr_x, spr_y, s1_spr_x, s1_spr_y;
    logic [7:0]  out_r, out_g, out_b, s1_out_r, s1_out_g, s1_out_b;
    logic        out_de, s1_out_de;

    int tests = 0;
    int fails = 0;
    logic [4:0] blink_pat = 5'b10011;

    always #5 clk = ~clk;

    sprite_compositor #(.SPR_W(16), .SPR_H(16), .SHIFT(0), .BLINK_FRAMES(2)) u_dut (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .de(de),
        .frame_start(frame_start), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
        .pos_x(pos_x), .pos_y(pos_y), .show(show), .blink(blink),
        .spr_x(spr_x), .spr_y(spr_y), .rom_r(rom_r), .rom_g(rom_g), .rom_b(rom_b),
        .rom_mask(rom_mask), .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_de(out_de)
    );

    sprite_compositor #(.SPR_W(16), .SPR_H(16), .SHIFT(1), .BLINK_FRAMES(2)) u_dut_s1 (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .de(de),
        .frame_start(frame_start), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
        .pos_x(pos_x), .pos_y(pos_y), .show(show), .blink(blink),
        .spr_x(s1_spr_x), .spr_y(s1_spr_y), .rom_r(rom_r), .rom_g(rom_g), .rom_b(rom_b),
        .rom_mask(rom_mask), .out_r(s1_out_r), .out_g(s1_out_g), .out_b(s1_out_b),
        .out_de(s1_out_de)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic [10:0] x, input logic [10:0] y, input logic d);
        pix_x = x;
        pix_y = y;
        de    = d;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // One in-box pixel at (3,3), then check the composited red two clocks later.
    task automatic probe(input string tag, input logic [31:0] exp_r);
        px(3, 3, 1'b1);
        tick();
        px(0, 0, 1'b0);
        tick();
        chk(tag, 32'(out_r), exp_r);
    endtask

    initial begin
        rst = 1'b1;
        px(0, 0, 1'b0);
        frame_start = 1'b0;
        pos_x = 0; pos_y = 0;
        show = 1'b0; blink = 1'b0;
        bg_r = 8'h20; bg_g = 8'h21; bg_b = 8'h22;
        rom_r = 8'h50; rom_g = 8'h51; rom_b = 8'h52; rom_mask = 1'b1;
        tick();
        tick();
        chk("rst_out_r", 32'(out_r), 'h0);
        chk("rst_out_de", 32'(out_de), 'h0);
        chk("rst_spr_x", 32'(spr_x), 'h0);
        chk("rst_spr_y", 32'(spr_y), 'h0);
        rst = 1'b0;

        // Latch (100,50) and enable; FSM goes HIDDEN -> VISIBLE.
        pos_x = 100; pos_y = 50; show = 1'b1;
        pulse_fs();

        px(100, 50, 1'b1);
        tick();
        chk("tl_spr_x", 32'(spr_x), 'h0);
        chk("tl_spr_y", 32'(spr_y), 'h0);
        chk("lat1_out_de", 32'(out_de), 'h0);
        px(115, 65, 1'b1);
        tick();
        chk("br_spr_x", 32'(spr_x), 15);
        chk("br_spr_y", 32'(spr_y), 15);
        chk("lat2_out_de", 32'(out_de), 'h1);
        chk("lat2_out_r", 32'(out_r), 'h50);
        chk("lat2_out_g", 32'(out_g), 'h51);
        px(116, 50, 1'b1);
        tick();
        chk("right_edge_spr_x", 32'(spr_x), 'h0);
        chk("br_out_r", 32'(out_r), 'h50);
        px(0, 0, 1'b0);
        tick();
        chk("outside_out_r", 32'(out_r), 'h20);
        chk("outside_out_b", 32'(out_b), 'h22);
        chk("outside_out_de", 32'(out_de), 'h1);
        tick();
        chk("de_drop_out_de", 32'(out_de), 'h0);

        // Transparent ROM pixel inside the box shows background.
        rom_mask = 1'b0;
        px(105, 55, 1'b1);
        tick();
        px(0, 0, 1'b0);
        tick();
        chk("mask0_out_r", 32'(out_r), 'h20);
        rom_mask = 1'b1;

        // pos_x moves mid-frame: sprite must stay at 100.
        pos_x = 300;
        px(100, 50, 1'b1);
        tick();
        px(300, 50, 1'b1);
        tick();
        chk("notear_old_pos", 32'(out_r), 'h50);
        px(0, 0, 1'b0);
        tick();
        chk("notear_new_pos", 32'(out_r), 'h20);

        // frame_start with de=1: that pixel still sees the old position.
        frame_start = 1'b1;
        px(300, 50, 1'b1);
        tick();
        frame_start = 1'b0;
        px(310, 50, 1'b1);
        tick();
        chk("fs_de_spr_x", 32'(spr_x), 10);
        chk("fs_de_old_pos_out", 32'(out_r), 'h20);
        px(0, 0, 1'b0);
        tick();
        chk("fs_de_new_pos_out", 32'(out_r), 'h50);

        // Right screen edge: box clips at 2047, no wrap to x=0.
        pos_x = 2040;
        pulse_fs();
        px(2047, 50, 1'b1);
        tick();
        chk("edge_spr_x", 32'(spr_x), 7);
        px(5, 50, 1'b1);
        tick();
        chk("edge_nowrap_spr_x", 32'(spr_x), 'h0);
        chk("edge_out_r", 32'(out_r), 'h50);
        px(0, 0, 1'b0);
        tick();
        chk("edge_nowrap_out_r", 32'(out_r), 'h20);

        // SHIFT=1 instance: 32x32 box at origin.
        pos_x = 0; pos_y = 0;
        pulse_fs();
        px(31, 31, 1'b1);
        tick();
        chk("s1_spr_x", 32'(s1_spr_x), 15);
        chk("s1_spr_y", 32'(s1_spr_y), 15);
        chk("s0_outside_spr_x", 32'(spr_x), 'h0);
        px(32, 0, 1'b1);
        tick();
        chk("s1_out_spr_x", 32'(s1_spr_x), 'h0);
        chk("s1_in_out_r", 32'(s1_out_r), 'h50);
        px(0, 0, 1'b0);
        tick();
        chk("s1_out_out_r", 32'(s1_out_r), 'h20);

        // Blink sequence starting from HIDDEN.
        show = 1'b0;
        pulse_fs();
        probe("hidden_out_r", 'h20);
        show = 1'b1; blink = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pulse_fs();
            probe($sformatf("blink_f%0d", i), blink_pat[i] ? 'h50 : 'h20);
        end
        show = 1'b0;
        probe("show_waits_fs", 'h50);
        pulse_fs();
        probe("blink_drop_show", 'h20);

        // Async reset between edges while inside the box.
        show = 1'b1; blink = 1'b0;
        pulse_fs();
        px(5, 6, 1'b1);
        tick();
        tick();
        chk("pre_rst_out_de", 32'(out_de), 'h1);
        chk("pre_rst_spr_x", 32'(spr_x), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_out_r", 32'(out_r), 'h0);
        chk("async_out_de", 32'(out_de), 'h0);
        chk("async_spr_x", 32'(spr_x), 'h0);
        chk("async_spr_y", 32'(spr_y), 'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rel_1clk_out_de", 32'(out_de), 'h0);
        tick();
        chk("rel_2clk_out_de", 32'(out_de), 'h1);
        chk("rel_bg_only_out_r", 32'(out_r), 'h20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
